// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI mode-0 target: register map, CTRL/STATUS
// bit positions, FSM states and the RXDATA word layout.
package spi_slave_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADR_W  = 14;
   localparam int unsigned BYTE_W = 8;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RXDATA = 2'd2;
   localparam logic [1:0] REG_TXDATA = 2'd3;

   localparam int unsigned CTRL_ENABLE    = 0;
   localparam int unsigned CTRL_RX_INT_EN = 1;
   localparam int unsigned CTRL_RX_OVF    = 8;

   localparam int unsigned ST_RX_EMPTY    = 0;
   localparam int unsigned ST_RX_FULL     = 1;
   localparam int unsigned ST_TX_PENDING  = 2;
   localparam int unsigned ST_BUSY        = 3;
   localparam int unsigned ST_RX_COUNT_LO = 4;

   localparam logic [BYTE_W-1:0] TX_IDLE_DEFAULT = 8'hFF;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

   typedef struct packed {
      logic [22:0]       zero;
      logic              valid;
      logic [BYTE_W-1:0] data;
   } rxdata_word_t;

endpackage

// File: rtl/spi_slave_io_if.sv
// dma_io register bus as seen by one peripheral in the read-data daisy chain.
interface spi_slave_io_if;
   import spi_slave_pkg::*;

   logic              dma_io_we;
   logic [ADR_W-1:0]  dma_io_wadr;
   logic [DATA_W-1:0] dma_io_wdata;
   logic [ADR_W-1:0]  dma_io_radr;
   logic              dma_io_radr_en;
   logic [DATA_W-1:0] dma_io_rdata_in;
   logic [DATA_W-1:0] dma_io_rdata;

   modport master (
      output dma_io_we, dma_io_wadr, dma_io_wdata,
      output dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
      input  dma_io_rdata
   );

   modport slave (
      input  dma_io_we, dma_io_wadr, dma_io_wdata,
      input  dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
      output dma_io_rdata
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous power-of-two FIFO for received SPI bytes.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module spi_rx_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign rdata   = mem_q[rptr_q];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/spi_slave_io.sv
// SPI mode-0 target on the dma_io bus: oversampled sck/csn/mosi, RX FIFO,
// TX holding register and a daisy-chained register read port.
module spi_slave_io
   import spi_slave_pkg::*;
#(
   parameter logic [15:0]       IO_BASE  = 16'hC400,
   parameter int unsigned       RX_DEPTH = 4,
   parameter logic [BYTE_W-1:0] TX_IDLE  = TX_IDLE_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           spi_sck,
   input  logic           spi_csn,
   input  logic           spi_mosi,
   output logic           spi_miso,
   output logic           spi_miso_en,
   output logic           spi_rx_int,
   spi_slave_io_if.slave  bus
);
   localparam int unsigned CNT_W    = $clog2(RX_DEPTH) + 1;
   localparam logic [11:0] BASE_TAG = IO_BASE[15:4];

   logic [2:0]        sck_sync_q, sck_sync_d;
   logic [2:0]        csn_sync_q, csn_sync_d;
   logic [2:0]        mosi_sync_q, mosi_sync_d;
   spi_state_e        state_q, state_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic              reload_q, reload_d;
   logic [BYTE_W-1:0] rx_sr_q, rx_sr_d;
   logic [BYTE_W-1:0] tx_sr_q, tx_sr_d;
   logic [BYTE_W-1:0] tx_hold_q, tx_hold_d;
   logic              tx_pending_q, tx_pending_d;
   logic              enable_q, enable_d;
   logic              rx_int_en_q, rx_int_en_d;
   logic              rx_ovf_q, rx_ovf_d;
   logic              rd_hit_q, rd_hit_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              sck_rise, sck_fall, csn_fall, csn_rise, mosi_s;
   logic              wr_hit, rd_hit;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [BYTE_W-1:0] fifo_rdata, rx_byte;
   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] rd_value;
   rxdata_word_t      rx_word;
   logic              unused_wdata;

   // Edges come from the settled stage 2 against stage 3.
   assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
   assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
   assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
   assign mosi_s   = mosi_sync_q[1];
   assign rx_byte  = {rx_sr_q[BYTE_W-2:0], mosi_s};

   assign wr_hit   = bus.dma_io_we & (bus.dma_io_wadr[ADR_W-1:2] == BASE_TAG);
   assign rd_hit   = bus.dma_io_radr_en & (bus.dma_io_radr[ADR_W-1:2] == BASE_TAG);
   assign fifo_pop = rd_hit & (bus.dma_io_radr[1:0] == REG_RXDATA);
   assign unused_wdata = ^bus.dma_io_wdata[DATA_W-1:CTRL_RX_OVF+1];

   spi_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (BYTE_W)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (rx_byte),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rx_word       = '0;
      rx_word.valid = ~fifo_empty;
      rx_word.data  = fifo_empty ? '0 : fifo_rdata;
      rd_value      = '0;
      case (bus.dma_io_radr[1:0])
         REG_CTRL: begin
            rd_value[CTRL_ENABLE]    = enable_q;
            rd_value[CTRL_RX_INT_EN] = rx_int_en_q;
            rd_value[CTRL_RX_OVF]    = rx_ovf_q;
         end
         REG_STATUS: begin
            rd_value[ST_RX_EMPTY]                     = fifo_empty;
            rd_value[ST_RX_FULL]                      = fifo_full;
            rd_value[ST_TX_PENDING]                   = tx_pending_q;
            rd_value[ST_BUSY]                         = ~csn_sync_q[1];
            rd_value[ST_RX_COUNT_LO +: 4]             = 4'(fifo_count);
         end
         REG_RXDATA: rd_value = DATA_W'(rx_word);
         default:    rd_value = '0;
      endcase
   end

   // Next-state: synchronisers, shift FSM, register writes, read capture.
   always_comb begin
      sck_sync_d   = {sck_sync_q[1:0], spi_sck};
      csn_sync_d   = {csn_sync_q[1:0], spi_csn};
      mosi_sync_d  = {mosi_sync_q[1:0], spi_mosi};
      state_d      = state_q;
      bitcnt_d     = bitcnt_q;
      reload_d     = reload_q;
      rx_sr_d      = rx_sr_q;
      tx_sr_d      = tx_sr_q;
      tx_hold_d    = tx_hold_q;
      tx_pending_d = tx_pending_q;
      enable_d     = enable_q;
      rx_int_en_d  = rx_int_en_q;
      rx_ovf_d     = rx_ovf_q;
      fifo_push    = 1'b0;
      rd_hit_d     = rd_hit;
      rdata_d      = rd_hit ? rd_value : '0;

      case (state_q)
         IDLE: begin
            if (enable_q && csn_fall) begin
               tx_sr_d      = tx_pending_q ? tx_hold_q : TX_IDLE;
               tx_pending_d = 1'b0;
               bitcnt_d     = '0;
               reload_d     = 1'b0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               bitcnt_d = '0;
               reload_d = 1'b0;
               state_d  = IDLE;
            end else if (sck_rise) begin
               rx_sr_d  = rx_byte;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
                  fifo_push = 1'b1;
                  reload_d  = 1'b1;
               end
            end else if (sck_fall) begin
               if (reload_q) begin
                  tx_sr_d      = tx_pending_q ? tx_hold_q : TX_IDLE;
                  tx_pending_d = 1'b0;
                  reload_d     = 1'b0;
               end else begin
                  tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Disabling drops the frame in progress; FIFO and TX state survive.
      if (!enable_q) begin
         state_d   = IDLE;
         bitcnt_d  = '0;
         reload_d  = 1'b0;
         fifo_push = 1'b0;
      end

      if (wr_hit && bus.dma_io_wadr[1:0] == REG_CTRL) begin
         enable_d    = bus.dma_io_wdata[CTRL_ENABLE];
         rx_int_en_d = bus.dma_io_wdata[CTRL_RX_INT_EN];
         if (bus.dma_io_wdata[CTRL_RX_OVF]) rx_ovf_d = 1'b0;
      end
      if (wr_hit && bus.dma_io_wadr[1:0] == REG_TXDATA) begin
         tx_hold_d    = bus.dma_io_wdata[BYTE_W-1:0];
         tx_pending_d = 1'b1;
      end

      // A push into a full FIFO is lost unless a pop lands in the same cycle.
      if (fifo_push && fifo_full && !fifo_pop) rx_ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_q   <= 3'b000;
         csn_sync_q   <= 3'b111;
         mosi_sync_q  <= 3'b000;
         state_q      <= IDLE;
         bitcnt_q     <= '0;
         reload_q     <= 1'b0;
         rx_sr_q      <= '0;
         tx_sr_q      <= TX_IDLE;
         tx_hold_q    <= '0;
         tx_pending_q <= 1'b0;
         enable_q     <= 1'b0;
         rx_int_en_q  <= 1'b0;
         rx_ovf_q     <= 1'b0;
         rd_hit_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         sck_sync_q   <= sck_sync_d;
         csn_sync_q   <= csn_sync_d;
         mosi_sync_q  <= mosi_sync_d;
         state_q      <= state_d;
         bitcnt_q     <= bitcnt_d;
         reload_q     <= reload_d;
         rx_sr_q      <= rx_sr_d;
         tx_sr_q      <= tx_sr_d;
         tx_hold_q    <= tx_hold_d;
         tx_pending_q <= tx_pending_d;
         enable_q     <= enable_d;
         rx_int_en_q  <= rx_int_en_d;
         rx_ovf_q     <= rx_ovf_d;
         rd_hit_q     <= rd_hit_d;
         rdata_q      <= rdata_d;
      end
   end

   assign spi_miso         = tx_sr_q[BYTE_W-1];
   assign spi_miso_en      = enable_q & ~csn_sync_q[1];
   assign spi_rx_int       = rx_int_en_q & ~fifo_empty;
   assign bus.dma_io_rdata = rd_hit_q ? rdata_q : bus.dma_io_rdata_in;
endmodule

// File: tb/tb_spi_slave_io.sv
// Bench for spi_slave_io: a bit-banged SPI master at clk/8 plus bus tasks,
// checked against a byte-level model of the register and FIFO behaviour.
module tb_spi_slave_io;
   import spi_slave_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam logic [15:0] BASE  = 16'hC400;

   logic clk = 1'b0;
   logic rst;
   logic sck, csn, mosi, miso, miso_en, rx_int;

   always #5 clk = ~clk;

   spi_slave_io_if bus ();

   spi_slave_io #(
      .IO_BASE  (BASE),
      .RX_DEPTH (DEPTH),
      .TX_IDLE  (8'hFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .spi_sck     (sck),
      .spi_csn     (csn),
      .spi_mosi    (mosi),
      .spi_miso    (miso),
      .spi_miso_en (miso_en),
      .spi_rx_int  (rx_int),
      .bus         (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [7:0]  q_rx[$];
   logic        m_en, m_int_en, m_ovf, m_pend;
   logic [7:0]  m_hold, m_cur;
   logic [31:0] conc_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_status();
      int n = q_rx.size();
      return {24'd0, 4'(n), ~csn, m_pend, (n == int'(DEPTH)), (n == 0)};
   endfunction

   function automatic logic [31:0] exp_ctrl();
      return {23'd0, m_ovf, 6'd0, m_int_en, m_en};
   endfunction

   function automatic logic [7:0] model_next_tx();
      logic [7:0] b = m_pend ? m_hold : 8'hFF;
      m_pend = 1'b0;
      return b;
   endfunction

   function automatic void model_push(input logic [7:0] b);
      if (q_rx.size() < int'(DEPTH)) q_rx.push_back(b);
      else m_ovf = 1'b1;
   endfunction

   task automatic wr(input logic [4:0] off, input logic [31:0] d);
      bus.dma_io_wadr  = 14'((32'(BASE) + 32'(off)) >> 2);
      bus.dma_io_wdata = d;
      bus.dma_io_we    = 1'b1;
      wait_clk(1);
      bus.dma_io_we    = 1'b0;
   endtask

   task automatic rd(input logic [4:0] off, output logic [31:0] d);
      bus.dma_io_radr    = 14'((32'(BASE) + 32'(off)) >> 2);
      bus.dma_io_radr_en = 1'b1;
      wait_clk(1);
      bus.dma_io_radr_en = 1'b0;
      d = bus.dma_io_rdata;
   endtask

   task automatic set_ctrl(input logic en, input logic ie, input logic w1c);
      wr(5'h00, {23'd0, w1c, 6'd0, ie, en});
      m_en = en;
      m_int_en = ie;
      if (w1c) m_ovf = 1'b0;
   endtask

   task automatic load_tx(input logic [7:0] b);
      wr(5'h0C, {24'd0, b});
      m_hold = b;
      m_pend = 1'b1;
   endtask

   task automatic rd_rx(input string tag);
      logic [31:0] d, e;
      rd(5'h08, d);
      if (q_rx.size() > 0) e = {23'd0, 1'b1, q_rx.pop_front()};
      else e = 32'd0;
      check(tag, d, e);
   endtask

   task automatic rd_status(input string tag);
      logic [31:0] d;
      rd(5'h04, d);
      check(tag, d, exp_status());
   endtask

   task automatic rd_ctrl(input string tag);
      logic [31:0] d;
      rd(5'h00, d);
      check(tag, d, exp_ctrl());
   endtask

   // One mode-0 bit: mosi set up, miso sampled, then a 4-clk-high sck pulse.
   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      wait_clk(4);
      m = miso;
      sck = 1'b1;
      wait_clk(4);
      sck = 1'b0;
   endtask

   // mode 1 watches the interrupt after the 8th rising edge; mode 2 issues an
   // RXDATA read in the very cycle the byte is pushed.
   task automatic spi_byte(input logic [7:0] tx, input int mode, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         if (i > 0 || mode == 0) begin
            spi_bit(tx[i], rx[i]);
         end else begin
            mosi = tx[i];
            wait_clk(4);
            rx[i] = miso;
            sck = 1'b1;
            if (mode == 1) begin
               int lat = 0;
               for (int c = 1; c <= 4; c++) begin
                  wait_clk(1);
                  if (rx_int && lat == 0) lat = c;
               end
               check("int_rise_within_4", 32'(lat >= 1 && lat <= 4), 32'd1);
            end else begin
               wait_clk(2);
               bus.dma_io_radr    = 14'((32'(BASE) + 32'h8) >> 2);
               bus.dma_io_radr_en = 1'b1;
               wait_clk(1);
               bus.dma_io_radr_en = 1'b0;
               conc_data = bus.dma_io_rdata;
               wait_clk(1);
            end
            sck = 1'b0;
         end
      end
   endtask

   task automatic frame_begin();
      csn = 1'b0;
      wait_clk(5);
      check("miso_en_in_frame", 32'(miso_en), 32'(m_en));
      if (m_en) m_cur = model_next_tx();
   endtask

   task automatic frame_end();
      wait_clk(4);
      csn = 1'b1;
      wait_clk(6);
   endtask

   task automatic send_byte(input logic [7:0] b, input int mode, input string tag);
      logic [7:0] got;
      logic [31:0] e;
      spi_byte(b, mode, got);
      check({tag, "_miso"}, 32'(got), 32'(m_cur));
      if (mode == 2) begin
         e = (q_rx.size() > 0) ? {23'd0, 1'b1, q_rx.pop_front()} : 32'd0;
         check({tag, "_conc_rd"}, conc_data, e);
      end
      model_push(b);
      m_cur = model_next_tx();
   endtask

   initial begin
      logic [31:0] d;
      logic        m;
      rst = 1'b1;
      sck = 1'b0; csn = 1'b1; mosi = 1'b0;
      bus.dma_io_we = 1'b0; bus.dma_io_wadr = '0; bus.dma_io_wdata = '0;
      bus.dma_io_radr = '0; bus.dma_io_radr_en = 1'b0;
      bus.dma_io_rdata_in = 32'hDEADBEEF;
      m_en = 0; m_int_en = 0; m_ovf = 0; m_pend = 0; m_hold = 0; m_cur = 8'hFF;
      conc_data = 0;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);

      // Reset state
      check("rst_miso", 32'(miso), 32'd1);
      check("rst_miso_en", 32'(miso_en), 32'd0);
      check("rst_rx_int", 32'(rx_int), 32'd0);
      check("rst_passthru", bus.dma_io_rdata, 32'hDEADBEEF);
      rd_status("rst_status");
      rd_ctrl("rst_ctrl");

      // Single byte 0xA5
      set_ctrl(1, 0, 0);
      rd_status("a5_status_pre");
      frame_begin(); send_byte(8'hA5, 0, "a5"); frame_end();
      rd_status("a5_status_post");
      rd_rx("a5_rxdata");
      rd_status("a5_status_empty");

      // TX byte then 2-byte frame
      load_tx(8'h3C);
      rd_status("tx_pending_set");
      frame_begin();
      rd_status("tx_pending_clr_at_csn");
      send_byte(8'h11, 0, "b0");
      send_byte(8'h22, 0, "b1");
      frame_end();
      rd_rx("two_rx0");
      rd_rx("two_rx1");

      // Overflow: five bytes into a 4-deep FIFO
      frame_begin();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, $sformatf("ovf%0d", i));
      frame_end();
      rd_status("ovf_status_full");
      rd_ctrl("ovf_ctrl_set");
      set_ctrl(1, 0, 1);
      rd_ctrl("ovf_ctrl_cleared");

      // Full FIFO: pop and push land together, no overflow
      frame_begin(); send_byte(8'h5A, 2, "conc"); frame_end();
      rd_ctrl("conc_no_ovf");
      rd_status("conc_count_same");
      for (int i = 0; i < 4; i++) rd_rx($sformatf("drain%0d", i));

      // Partial frame discarded
      csn = 1'b0; wait_clk(5);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
      frame_end();
      frame_begin(); send_byte(8'h77, 0, "x77"); frame_end();
      rd_status("partial_status");
      rd_rx("partial_rx77");
      rd_rx("partial_empty");

      // Interrupt rise/fall
      set_ctrl(1, 1, 0);
      check("int_idle_low", 32'(rx_int), 32'd0);
      frame_begin(); send_byte(8'h96, 1, "int"); send_byte(8'h69, 0, "int2"); frame_end();
      rd_rx("int_rx0");
      check("int_high_before_last", 32'(rx_int), 32'd1);
      rd_rx("int_rx1");
      check("int_low_after_pop", 32'(rx_int), 32'd0);

      // Out-of-window read passes through; no pop
      load_tx(8'hC3);
      frame_begin(); send_byte(8'h42, 0, "pt"); frame_end();
      rd(5'h10, d);
      check("oow_passthru", d, 32'hDEADBEEF);
      rd_status("oow_no_pop");
      bus.dma_io_rdata_in = $urandom;
      wait_clk(1);
      check("passthru_comb", bus.dma_io_rdata, bus.dma_io_rdata_in);
      rd_rx("oow_rx42");

      // Disabling mid-frame drops the partial byte
      set_ctrl(1, 0, 0);
      frame_begin();
      for (int i = 0; i < 3; i++) spi_bit(1'b0, m);
      set_ctrl(0, 0, 0);
      check("dis_miso_en", 32'(miso_en), 32'd0);
      set_ctrl(1, 0, 0);
      for (int i = 0; i < 5; i++) spi_bit(1'b0, m);
      frame_end();
      rd_status("dis_status");

      // Randomised traffic
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 4))
            0: load_tx(8'($urandom));
            1: begin
               int nb = $urandom_range(1, 3);
               frame_begin();
               for (int k = 0; k < nb; k++) send_byte(8'($urandom), 0, $sformatf("r%0d_%0d", it, k));
               frame_end();
            end
            2: rd_rx($sformatf("r%0d_rx", it));
            3: rd_status($sformatf("r%0d_status", it));
            default: begin
               rd_ctrl($sformatf("r%0d_ctrl", it));
               set_ctrl(1, 1'($urandom), 1);
            end
         endcase
         check($sformatf("r%0d_int", it), 32'(rx_int), 32'(m_int_en && q_rx.size() > 0));
      end
      rd_status("final_status");
      rd_ctrl("final_ctrl");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
